avmm_edge_pio_in: RTL

// - Parametrised Avalon-MM input PIO; successor to the 3-bit level-IRQ handshake port.
// - Adds a synchroniser, optional per-bit debounce, edge capture with write-1-to-clear, and level/edge IRQ modes.
// - Sits between the Qsys interconnect and asynchronous external status lines (vision pipeline handshakes, buttons).

---
 rtl/qsys_pio_defs.sv | 27 ++
 rtl/pio_in_bit_filter.sv | 58 +++++
 rtl/avmm_edge_pio_in.sv | 92 +++++++++
 3 files changed

// File: rtl/qsys_pio_defs.sv
// Shared register map and edge-mode encodings for the Qsys input PIO family.
package qsys_pio_defs;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_RSVD    = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } pio_addr_e;

  localparam int unsigned EDGE_LEVEL = 0;
  localparam int unsigned EDGE_RISE  = 1;
  localparam int unsigned EDGE_FALL  = 2;
  localparam int unsigned EDGE_ANY   = 3;

  // Level mode still reports rising edges so EDGECAP stays meaningful.
  function automatic logic [31:0] edge_select(input int unsigned mode,
                                              input logic [31:0] rise,
                                              input logic [31:0] fall);
    case (mode)
      EDGE_FALL: edge_select = fall;
      EDGE_ANY:  edge_select = rise | fall;
      default:   edge_select = rise;
    endcase
  endfunction

endpackage

// File: rtl/pio_in_bit_filter.sv
// One input bit: multi-flop synchroniser followed by an optional debounce filter.
module pio_in_bit_filter #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic filt_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;
  logic                   filt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
  end

  assign sync_bit = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) filt_q <= 1'b0;
        else          filt_q <= sync_bit;
      end
    end else begin : g_debounce
      localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
      logic [CW-1:0] cnt_q, cnt_d;
      logic          filt_d;

      // Counter only runs while the synchronised bit disagrees with the output.
      always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_bit != filt_q) begin
          if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) filt_d = ~filt_q;
          else                                   cnt_d  = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q  <= '0;
          filt_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          filt_q <= filt_d;
        end
      end
    end
  endgenerate

  assign filt_o = filt_q;

endmodule

// File: rtl/avmm_edge_pio_in.sv
// Avalon-MM input PIO with synchroniser, debounce, W1C edge capture and level/edge IRQ.
module avmm_edge_pio_in
  import qsys_pio_defs::*;
#(
  parameter int unsigned WIDTH           = 3,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port
);

  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] filt_dly_q;
  logic [WIDTH-1:0] rise, fall, edge_ev, clr;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_in_bit_filter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filt (
      .clk    (clk),
      .reset_n(reset_n),
      .in_i   (in_port[i]),
      .filt_o (filt[i])
    );
  end

  if (WIDTH < 32) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

  assign rise    = filt & ~filt_dly_q;
  assign fall    = ~filt & filt_dly_q;
  assign edge_ev = WIDTH'(edge_select(EDGE_MODE, 32'(rise), 32'(fall)));
  assign wr_en   = chipselect & ~write_n;

  // New edges are OR-ed in after the clear so a same-cycle edge survives a W1C.
  always_comb begin
    irq_mask_d = irq_mask_q;
    clr        = '0;
    if (wr_en && address == ADDR_IRQMASK) irq_mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_EDGECAP) clr        = writedata[WIDTH-1:0];
    edge_cap_d = (edge_cap_q & ~clr) | edge_ev;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d = 32'(filt);
      ADDR_IRQMASK: readdata_d = 32'(irq_mask_q);
      ADDR_EDGECAP: readdata_d = 32'(edge_cap_q);
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_dly_q <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
    end else begin
      filt_dly_q <= filt;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
    end
  end

  if (EDGE_MODE == EDGE_LEVEL) begin : g_irq_level
    assign irq = |(filt & irq_mask_q);
  end else begin : g_irq_edge
    assign irq = |(edge_cap_q & irq_mask_q);
  end

  assign readdata = readdata_q;

endmodule
